reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//  Multi-read-port, single-write-port synchronous register file; next-generation block for the accelerator's on-chip buffers.
//  Generalises the 2R/1W file with:
//  - parametrised read-port count;
//  - byte-enabled writes;
//  - read-during-write forwarding;
//  - per-port read-valid;
//  - optional output register stage;
//  - hardware clear-on-reset sequencer.
//  Sits between controller/address generators and compute lanes needing several operands per cycle.
// PARAMETERS
//  DATA_WIDTH     32  word width, bits; must be a multiple of BYTE_WIDTH
//  ADDR_WIDTH     4   address width; DEPTH = 1<<ADDR_WIDTH words
//  NUM_RD         2   number of independent read ports (1..8)
//  BYTE_WIDTH     8   bits per write-enable lane; NUM_BE = DATA_WIDTH/BYTE_WIDTH
//  OUT_REG        0   1 adds a second output register stage (read latency 2)
//  INIT_ON_RESET  1   1 zero-fills all words after reset; 0 skips fill (init_done rises 1 cycle after reset release)
// PORTS
//  clk        in   1                  clock; all logic on rising edge
//  resetn     in   1                  synchronous, active-low reset
//  rd_req     in   NUM_RD             per-port read request
//  rd_addr    in   NUM_RD*ADDR_WIDTH  packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  rd_data    out  NUM_RD*DATA_WIDTH  packed read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rd_valid   out  NUM_RD             per-port pulse: rd_data slice holds data for the accepted request
//  wr_req     in   1                  write request
//  wr_addr    in   ADDR_WIDTH         write address
//  wr_data    in   DATA_WIDTH         write data
//  wr_be      in   NUM_BE             byte-lane enables; lane j covers [j*BYTE_WIDTH +: BYTE_WIDTH]
//  init_done  out  1                  1 = file ready; requests are only accepted while 1
// BEHAVIOUR
//  Reset (resetn==0 at a clock edge):
//  - rd_data=0, rd_valid=0, init_done=0, internal pipeline regs cleared; FSM -> INIT, clear pointer = 0.
//  FSM states:
//  - INIT: writes 0 to mem[ptr], ptr++ each cycle; after ptr==DEPTH-1 -> READY.
//    Fill takes DEPTH cycles; init_done rises on the following edge.
//    If INIT_ON_RESET==0, INIT lasts exactly 1 cycle and writes nothing.
//  - READY: normal operation; init_done=1; remains until resetn==0.
//  - Reset mid-INIT or mid-READY: immediate return to INIT at ptr 0; in-flight reads are dropped (rd_valid forced 0).
//  Gating:
//  - While init_done==0, rd_req and wr_req are ignored: no memory update, no rd_valid, rd_data holds 0.
//  Write (READY):
//  - On an edge with wr_req=1, each lane j with wr_be[j]=1 updates; lanes with wr_be[j]=0 keep old value.
//  - wr_be==0 with wr_req=1 is a legal no-op.
//  Read (READY):
//  - Request on port i accepted at edge T.
//  - OUT_REG=0: rd_data slice i and rd_valid[i]=1 valid after edge T; rd_valid[i] drops after T+1 if no new request.
//  - OUT_REG=1: same, one cycle later.
//  - rd_data slice i holds its last value when no request; it never returns to 0 except via reset.
//  - Ports are fully independent; any number may read the same address in the same cycle.
//  Read-during-write forwarding:
//  - Same edge, rd_addr_i==wr_addr, wr_req=1: returned word = old word with enabled lanes replaced by wr_data (write-first).
//  - Different addresses: old/new irrelevant, read returns stored value.
//  Address range:
//  - Full DEPTH range is valid; no out-of-range case.
//  - ptr and addresses wrap naturally at ADDR_WIDTH bits (ptr never exceeds DEPTH-1).
//  Storage:
//  - Memory array carries no reset; contents defined only via INIT fill or writes.
// TESTING
//  T1 reset/init: hold resetn=0 3 cycles, release.
//   -> init_done=0 for exactly 16 cycles then 1; every address reads 0x00000000.
//  T2 byte enables: mem[5]=0xAABBCCDD, write 0x11223344 with wr_be=4'b0101.
//   -> read returns 0xAA22CC44 with rd_valid after 1 cycle (2 if OUT_REG=1).
//  T3 forwarding: mem[3]=0x0, same edge wr 0xDEADBEEF be=4'hF addr 3 + rd port0 addr 3 + rd port1 addr 4.
//   -> port0 0xDEADBEEF, port1 unchanged mem[4].
//  T4 multi-port: NUM_RD=4, all ports read distinct addresses 0..3 back-to-back for 16 cycles.
//   -> each rd_valid high every cycle, data matches model, latency exactly 1/2.
//  T5 gating: assert wr_req/rd_req during INIT.
//   -> no rd_valid, memory still all 0 after init_done.
//  T6 reset mid-op: stream reads, drop resetn 1 cycle.
//   -> rd_valid=0 and rd_data=0 next cycle; INIT restarts from address 0; prior writes cleared.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port, single-write-port register file with byte
// enables, write-first forwarding, per-port read-valid, an optional second
// output stage and a zero-fill sequencer that runs after every reset.

// One read port: carries the looked-up word through one or two output stages.
// Data holds its last value whenever no new word arrives.
module reg_file_mp_rdport #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    logic [STAGES-1:0]                 vld_pipe_d, vld_pipe_q;
    logic [STAGES-1:0][DATA_WIDTH-1:0] dat_pipe_d, dat_pipe_q;

    // Shift the valid bit along; each data stage loads only when its feeder is valid.
    always_comb begin
        vld_pipe_d    = '0;
        dat_pipe_d    = dat_pipe_q;
        vld_pipe_d[0] = accept;
        if (accept) dat_pipe_d[0] = word;
        for (int s = 1; s < STAGES; s++) begin
            vld_pipe_d[s] = vld_pipe_q[s-1];
            if (vld_pipe_q[s-1]) dat_pipe_d[s] = dat_pipe_q[s-1];
        end
    end

    // Pipeline registers; reset drops any in-flight read and zeroes the data.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
        end
    end

    assign rd_data  = dat_pipe_q[STAGES-1];
    assign rd_valid = vld_pipe_q[STAGES-1];
endmodule

module reg_file_mp #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int NUM_RD        = 2,
    parameter int BYTE_WIDTH    = 8,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_RD-1:0]                rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]     rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data,
    output logic [NUM_RD-1:0]                rd_valid,
    input  logic                             wr_req,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
    output logic                             init_done
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NUM_BE = DATA_WIDTH / BYTE_WIDTH;

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e                  state_d, state_q;
    logic [ADDR_WIDTH-1:0]   ptr_d, ptr_q;
    logic                    ready, fill_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_fire;
    logic [DATA_WIDTH-1:0]   wr_merged;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr_a;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_word;
    logic [NUM_RD-1:0]                 rd_accept;

    // State and clear-pointer registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: walk the pointer over every word, then sit in READY until reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                if (INIT_ON_RESET != 0) begin
                    ptr_d = ptr_q + 1'b1;
                    if (&ptr_q) state_d = ST_READY;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    // FSM outputs: fill strobe during INIT, request gating in READY.
    always_comb begin
        ready   = (state_q == ST_READY);
        fill_we = (state_q == ST_INIT) && (INIT_ON_RESET != 0);
    end

    assign init_done = ready;
    assign wr_fire   = ready && wr_req;

    // Byte-lane merge of the write data into the currently stored word.
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int j = 0; j < NUM_BE; j++) begin
            if (wr_be[j]) wr_merged[j*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[j*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Single memory write port shared by the zero-fill and normal writes.
    always_comb begin
        mem_we    = resetn && (fill_we || (wr_fire && (|wr_be)));
        mem_waddr = fill_we ? ptr_q : wr_addr;
        mem_wdata = fill_we ? '0 : wr_merged;
    end

    // Storage array; deliberately unreset, defined by the fill sequence.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Per-port lookup with write-first forwarding of the merged word.
    always_comb begin
        rd_addr_a = rd_addr;
        rd_word   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (wr_fire && (rd_addr_a[i] == wr_addr)) rd_word[i] = wr_merged;
            else                                      rd_word[i] = mem[rd_addr_a[i]];
        end
        rd_accept = rd_req & {NUM_RD{ready}};
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_file_mp_rdport #(
            .DATA_WIDTH (DATA_WIDTH),
            .OUT_REG    (OUT_REG)
        ) u_port (
            .clk      (clk),
            .resetn   (resetn),
            .accept   (rd_accept[i]),
            .word     (rd_word[i]),
            .rd_data  (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid (rd_valid[i])
        );
    end
endmodule
